// File: rtl/ogpu_pio_in_edge_pkg.sv
// ogpu_pio_pkg: shared constants for the OpenGPU edge-capturing input PIO.
//
// Contents:
//   - Avalon-MM word offsets of the four register slots
//   - edge-type selector values for the EDGE_TYPE parameter
//   - bus widths shared by the interface and the top level
//   - a small helper that decodes a qualified register write
package ogpu_pio_pkg;

  localparam int OGPU_PIO_ADDR_W = 2;
  localparam int OGPU_PIO_DATA_W = 32;

  localparam logic [OGPU_PIO_ADDR_W-1:0] OGPU_PIO_DATA    = 2'd0;
  localparam logic [OGPU_PIO_ADDR_W-1:0] OGPU_PIO_RSVD    = 2'd1;
  localparam logic [OGPU_PIO_ADDR_W-1:0] OGPU_PIO_IRQMASK = 2'd2;
  localparam logic [OGPU_PIO_ADDR_W-1:0] OGPU_PIO_EDGECAP = 2'd3;

  localparam int OGPU_PIO_EDGE_RISE = 0;
  localparam int OGPU_PIO_EDGE_FALL = 1;
  localparam int OGPU_PIO_EDGE_ANY  = 2;

  // True when the bus is writing the register at word offset 'off'.
  function automatic logic ogpu_pio_wr_hit(
    input logic                       chipselect,
    input logic                       write_n,
    input logic [OGPU_PIO_ADDR_W-1:0] address,
    input logic [OGPU_PIO_ADDR_W-1:0] off
  );
    return chipselect & ~write_n & (address == off);
  endfunction

endpackage

// File: rtl/ogpu_pio_in_edge_if.sv
// ogpu_pio_in_edge_if: Avalon-MM slave bundle for the OpenGPU input PIO.
//
// Signals:
//   address     word offset (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect  slave select, qualifies writes only
//   write_n     active-low write strobe
//   writedata   write data, low WIDTH bits meaningful
//   readdata    registered read data, readLatency 1
//   irq         registered level interrupt
//
// Modports:
//   master  the HPS bridge side (drives address/control/writedata)
//   slave   the PIO side (drives readdata/irq)
interface ogpu_pio_in_edge_if;
  import ogpu_pio_pkg::*;

  logic [OGPU_PIO_ADDR_W-1:0] address;
  logic                       chipselect;
  logic                       write_n;
  logic [OGPU_PIO_DATA_W-1:0] writedata;
  logic [OGPU_PIO_DATA_W-1:0] readdata;
  logic                       irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );

endinterface

// File: rtl/ogpu_pio_in_edge_sync.sv
// ogpu_pio_sync: WIDTH-bit multi-flop synchronizer for the input PIO.
//
// Parameters:
//   WIDTH        number of bits carried
//   SYNC_STAGES  flop depth; 0 passes din straight through (already in clk)
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset, clears every stage
//   din      raw, possibly asynchronous inputs
//   dout     synchronized outputs (last stage, or din when bypassed)
module ogpu_pio_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (SYNC_STAGES == 0) begin : g_bypass

    // No flops in this configuration; clock and reset only feed the chain.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;

    assign dout = din;

  end else begin : g_chain

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
      stage_d    = stage_q;
      stage_d[0] = din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[SYNC_STAGES-1];

  end

endmodule

// File: rtl/ogpu_pio_in_edge.sv
// ogpu_pio_in_edge: Avalon-MM input PIO with per-bit edge capture for the
// OpenGPU status lines (quad store request, shader done, FIFO flags).
//
// Parameters:
//   WIDTH        input bits, 1..32
//   EDGE_TYPE    0 rising, 1 falling, 2 any edge
//   SYNC_STAGES  0 (bypass), 2 or 3
//
// Ports:
//   clk      system clock (single domain)
//   reset_n  asynchronous active-low reset
//   in_port  raw status inputs, possibly asynchronous
//   avs      Avalon-MM slave bundle (address, chipselect, write_n,
//            writedata, readdata, irq)
//
// Register map (word offsets):
//   0 data         synchronized in_port, read-only
//   1 reserved     reads 0, writes ignored
//   2 irqmask      read/write
//   3 edgecapture  read, write-1-to-clear
//
// Build option:
//   OGPU_PIO_IRQ_EN  when defined, the irqmask register and the masked
//                    interrupt exist; when undefined, offset 2 reads 0,
//                    writes to it are dropped and irq is held at 0.
module ogpu_pio_in_edge
  import ogpu_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = OGPU_PIO_EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    in_port,
  ogpu_pio_in_edge_if.slave   avs
);

  if (WIDTH < 1 || WIDTH > OGPU_PIO_DATA_W) begin : g_bad_width
    $error("ogpu_pio_in_edge: WIDTH must be 1..32");
  end
  if (SYNC_STAGES != 0 && SYNC_STAGES != 2 && SYNC_STAGES != 3) begin : g_bad_sync
    $error("ogpu_pio_in_edge: SYNC_STAGES must be 0, 2 or 3");
  end

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [WIDTH-1:0] edgecap_clr;
  logic [WIDTH-1:0] mask_rd;
  logic [WIDTH-1:0] wdata;
  logic             wr_edgecap;

  logic [OGPU_PIO_DATA_W-1:0] readdata_q;
  logic [OGPU_PIO_DATA_W-1:0] readdata_d;

  // Bits above WIDTH on the write bus have no destination.
  logic unused_wdata;
  assign unused_wdata = ^avs.writedata;

  assign wdata = avs.writedata[WIDTH-1:0];

  ogpu_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .dout    (sync_q)
  );

  // prev_q resets to 0, so a line already high when reset is released
  // registers one rising/any edge once the synchronizer has filled.
  assign prev_d = sync_q;

  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == OGPU_PIO_EDGE_FALL) begin
      edge_hit = ~sync_q & prev_q;
    end else if (EDGE_TYPE == OGPU_PIO_EDGE_ANY) begin
      edge_hit = sync_q ^ prev_q;
    end else begin
      edge_hit = sync_q & ~prev_q;
    end
  end

  assign wr_edgecap = ogpu_pio_wr_hit(avs.chipselect, avs.write_n,
                                      avs.address, OGPU_PIO_EDGECAP);

  // Clear is applied before set so a new edge in the clearing cycle survives.
  always_comb begin
    edgecap_clr = wr_edgecap ? wdata : '0;
    edgecap_d   = (edgecap_q & ~edgecap_clr) | edge_hit;
  end

`ifdef OGPU_PIO_IRQ_EN

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic             irq_q;
  logic             irq_d;
  logic             wr_mask;

  assign wr_mask = ogpu_pio_wr_hit(avs.chipselect, avs.write_n,
                                   avs.address, OGPU_PIO_IRQMASK);

  always_comb begin
    mask_d = wr_mask ? wdata : mask_q;
    // Built from the registered capture and mask, so irq trails a new
    // capture, a clear or a mask write by one clock.
    irq_d  = |(edgecap_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask_rd = mask_q;
  assign avs.irq = irq_q;

`else

  assign mask_rd = '0;
  assign avs.irq = 1'b0;

`endif

  // Read mux is re-registered every clock; no read strobe is needed.
  always_comb begin
    readdata_d = '0;
    case (avs.address)
      OGPU_PIO_DATA:    readdata_d[WIDTH-1:0] = sync_q;
      OGPU_PIO_IRQMASK: readdata_d[WIDTH-1:0] = mask_rd;
      OGPU_PIO_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:          readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= prev_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs.readdata = readdata_q;

endmodule

// File: tb/tb_ogpu_pio_in_edge.sv
// Bench for ogpu_pio_in_edge. Three instances share clk and reset_n:
//   d0: EDGE_TYPE 0 (rising),  SYNC_STAGES 2
//   d1: EDGE_TYPE 2 (any),     SYNC_STAGES 2
//   d2: EDGE_TYPE 1 (falling), SYNC_STAGES 0
// Stimulus pushes expected readdata/irq values with the cycle at which
// they must be visible; a monitor pops and compares them on negedges.
module tb_ogpu_pio_in_edge;
  import ogpu_pio_pkg::*;

`ifdef OGPU_PIO_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  addr_a [3];
  logic        cs_a   [3];
  logic        wn_a   [3];
  logic [31:0] wd_a   [3];
  logic [3:0]  in_a   [3];
  logic [31:0] rdata_w[3];
  logic        irq_w  [3];

  ogpu_pio_in_edge_if bus0();
  ogpu_pio_in_edge_if bus1();
  ogpu_pio_in_edge_if bus2();

  assign bus0.address = addr_a[0];
  assign bus0.chipselect = cs_a[0];
  assign bus0.write_n = wn_a[0];
  assign bus0.writedata = wd_a[0];
  assign rdata_w[0] = bus0.readdata;
  assign irq_w[0] = bus0.irq;

  assign bus1.address = addr_a[1];
  assign bus1.chipselect = cs_a[1];
  assign bus1.write_n = wn_a[1];
  assign bus1.writedata = wd_a[1];
  assign rdata_w[1] = bus1.readdata;
  assign irq_w[1] = bus1.irq;

  assign bus2.address = addr_a[2];
  assign bus2.chipselect = cs_a[2];
  assign bus2.write_n = wn_a[2];
  assign bus2.writedata = wd_a[2];
  assign rdata_w[2] = bus2.readdata;
  assign irq_w[2] = bus2.irq;

  ogpu_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_d0 (
    .clk(clk), .reset_n(reset_n), .in_port(in_a[0]), .avs(bus0));
  ogpu_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_d1 (
    .clk(clk), .reset_n(reset_n), .in_port(in_a[1]), .avs(bus1));
  ogpu_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(0)) u_d2 (
    .clk(clk), .reset_n(reset_n), .in_port(in_a[2]), .avs(bus2));

  typedef struct {
    int          due;
    int          dut;
    logic        is_irq;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event sb_kick;

  // Monitor: compare every entry whose cycle has been reached.
  chk_t        cur;
  logic [31:0] act;
  always @(negedge clk or sb_kick) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      act = cur.is_irq ? {31'b0, irq_w[cur.dut]} : rdata_w[cur.dut];
      n_tests++;
      if (act !== cur.exp) begin
        n_fail++;
        $display("FAIL %s (d%0d): actual 0x%08h required 0x%08h",
                 cur.name, cur.dut, act, cur.exp);
      end
    end
  end

  // lag 1: value visible after the next posedge; lag 0: visible now.
  task automatic push(input int d, input logic is_irq, input logic [31:0] e,
                      input string nm, input int lag);
    chk_t c;
    c.due = cyc + lag;
    c.dut = d;
    c.is_irq = is_irq;
    c.exp = e;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic chk_irq(input int d, input logic e, input string nm);
    push(d, 1'b1, {31'b0, e}, nm, 1);
  endtask

  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e,
                    input string nm);
    addr_a[d] = a;
    push(d, 1'b0, e, nm, 1);
    @(negedge clk);
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v,
                    input logic cs);
    addr_a[d] = a;
    cs_a[d] = cs;
    wn_a[d] = 1'b0;
    wd_a[d] = v;
    @(negedge clk);
    cs_a[d] = 1'b0;
    wn_a[d] = 1'b1;
    wd_a[d] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_a[i] = '0; cs_a[i] = 1'b0; wn_a[i] = 1'b1;
      wd_a[i] = '0; in_a[i] = '0;
    end

    // Reset
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_irq(i, 1'b0, "irq_in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    chk_irq(0, 1'b0, "irq_after_reset");
    rd(0, OGPU_PIO_DATA, 32'h0, "rst_data");
    rd(0, OGPU_PIO_IRQMASK, 32'h0, "rst_mask");
    rd(0, OGPU_PIO_EDGECAP, 32'h0, "rst_edgecap");

    // Rising capture on d0, mask 0x5
    wr(0, OGPU_PIO_IRQMASK, 32'h5, 1'b1);
    in_a[0] = 4'h5;                          // edge k is the next posedge
    @(negedge clk);
    @(negedge clk);
    chk_irq(0, 1'b0, "rise_irq_k2");
    rd(0, OGPU_PIO_DATA, 32'h5, "rise_data_k2");
    chk_irq(0, IRQ_EN, "rise_irq_k3");
    rd(0, OGPU_PIO_EDGECAP, 32'h5, "rise_edgecap");
    rd(0, OGPU_PIO_IRQMASK, IRQ_EN ? 32'h5 : 32'h0, "rise_mask_rd");
    wr(0, OGPU_PIO_EDGECAP, 32'h5, 1'b0);    // chipselect low: ignored
    rd(0, OGPU_PIO_EDGECAP, 32'h5, "no_cs_write");
    chk_irq(0, IRQ_EN, "clr1_irq_w");
    wr(0, OGPU_PIO_EDGECAP, 32'h1, 1'b1);
    chk_irq(0, IRQ_EN, "clr1_irq_w1");
    rd(0, OGPU_PIO_EDGECAP, 32'h4, "clr1_edgecap");
    chk_irq(0, IRQ_EN, "clr4_irq_w");
    wr(0, OGPU_PIO_EDGECAP, 32'h4, 1'b1);
    chk_irq(0, 1'b0, "clr4_irq_w1");
    rd(0, OGPU_PIO_EDGECAP, 32'h0, "clr4_edgecap");

    // Masking on d0
    wr(0, OGPU_PIO_IRQMASK, 32'h0, 1'b1);
    in_a[0] = 4'h7;                          // rise on bit 1 only
    repeat (4) @(negedge clk);
    chk_irq(0, 1'b0, "masked_irq");
    rd(0, OGPU_PIO_EDGECAP, 32'h2, "masked_edgecap");
    chk_irq(0, 1'b0, "mask_wr_irq_w");
    wr(0, OGPU_PIO_IRQMASK, 32'h2, 1'b1);
    chk_irq(0, IRQ_EN, "mask_wr_irq_w1");
    rd(0, OGPU_PIO_IRQMASK, IRQ_EN ? 32'h2 : 32'h0, "mask_wr_rd");

    // Set/clear collision on d1 (any edge)
    in_a[1] = 4'h1;
    repeat (4) @(negedge clk);
    rd(1, OGPU_PIO_EDGECAP, 32'h1, "any_rise_cap");
    in_a[1] = 4'h0;                          // edge k2 is the next posedge
    @(negedge clk);
    @(negedge clk);
    wr(1, OGPU_PIO_EDGECAP, 32'h1, 1'b1);    // lands on k2+2, the set edge
    rd(1, OGPU_PIO_EDGECAP, 32'h1, "collision_set_wins");
    wr(1, OGPU_PIO_EDGECAP, 32'h1, 1'b1);
    chk_irq(1, 1'b0, "any_irq_unmasked_none");
    rd(1, OGPU_PIO_EDGECAP, 32'h0, "plain_clear");

    // Falling edge on d2 (bypass synchronizer)
    wr(2, OGPU_PIO_IRQMASK, 32'h8, 1'b1);
    in_a[2] = 4'hF;
    rd(2, OGPU_PIO_DATA, 32'hF, "bypass_data");
    chk_irq(2, 1'b0, "fall_irq_pre");
    rd(2, OGPU_PIO_EDGECAP, 32'h0, "fall_no_rise_cap");
    in_a[2] = 4'h0;
    rd(2, OGPU_PIO_DATA, 32'h0, "bypass_data_low");
    chk_irq(2, IRQ_EN, "fall_irq");
    rd(2, OGPU_PIO_EDGECAP, 32'hF, "fall_edgecap");

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    push(2, 1'b0, 32'h0, "async_rst_rdata_d2", 0);
    push(2, 1'b1, 32'h0, "async_rst_irq_d2", 0);
    push(0, 1'b0, 32'h0, "async_rst_rdata_d0", 0);
    push(0, 1'b1, 32'h0, "async_rst_irq_d0", 0);
    ->sb_kick;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    // d0 holds 0x7 through reset: one rising capture after the sync fills
    repeat (4) @(negedge clk);
    chk_irq(0, 1'b0, "post_rst_irq");
    rd(0, OGPU_PIO_EDGECAP, 32'h7, "post_rst_held_high");
    rd(0, OGPU_PIO_IRQMASK, 32'h0, "post_rst_mask");
    rd(2, OGPU_PIO_EDGECAP, 32'h0, "post_rst_cap_d2");
    rd(1, OGPU_PIO_EDGECAP, 32'h0, "post_rst_cap_d1");

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: actual %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
